// File: rtl/fft_cmul_pipe.sv
// fft_cmul_pipe: fully pipelined complex multiplier for the R22SDF twiddle stage.
// It computes z = x * w, or z = x * conj(w) when conj_i is set, using three real
// multiplies (Karatsuba). Latency is 5 enabled cycles. The block supports selectable
// rounding, saturate or wrap, and a sticky overflow flag.
module fft_cmul_pipe #(
    parameter int DATA_WIDTH    = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10,
    parameter int ROUND_MODE    = 1,
    parameter int SATURATE      = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clr_ovf_i,
    input  logic                     conj_i,
    input  logic                     valid_i,
    input  logic [NLOG2-1:0]         ctr_i,
    input  logic [DATA_WIDTH-1:0]    x_re_i,
    input  logic [DATA_WIDTH-1:0]    x_im_i,
    input  logic [TWIDDLE_WIDTH-1:0] w_re_i,
    input  logic [TWIDDLE_WIDTH-1:0] w_im_i,
    output logic                     valid_o,
    output logic [NLOG2-1:0]         ctr_o,
    output logic [DATA_WIDTH-1:0]    z_re_o,
    output logic [DATA_WIDTH-1:0]    z_im_o,
    output logic                     ovf_o
);

    localparam int DW = DATA_WIDTH;
    localparam int TW = TWIDDLE_WIDTH;
    localparam int RW = DW + TW + 2;   // exact sum width out of S4
    localparam int SH = TW - 1;        // Q1.(TW-1) scaling shift
    localparam int QW = RW - SH;       // width of the scaled integer part
    localparam logic [SH-1:0] HALF = {1'b1, {(SH-1){1'b0}}};

    // stage 1: registered operands, w_im already conditionally negated at TW+1 bits
    logic signed [DW-1:0] s1_xre, s1_xim;
    logic signed [TW-1:0] s1_wre;
    logic signed [TW:0]   s1_wim;
    // stage 2: pre-adds at full width
    logic signed [DW-1:0] s2_xre, s2_xim;
    logic signed [TW-1:0] s2_wre;
    logic signed [DW:0]   s2_e;
    logic signed [TW+1:0] s2_cmd, s2_cpd;
    // stage 3/4: products and post-adds, all at RW so nothing is dropped
    logic signed [RW-1:0] s3_f, s3_pr, s3_pi;
    logic signed [RW-1:0] s4_r, s4_i;
    // valid and counter travel with the data
    logic [4:1]            vld_pipe;
    logic [4:1][NLOG2-1:0] ctr_pipe;

    logic signed [TW:0] wim_ext, wim_sel;
    logic [DW:0]        rs_re, rs_im;   // {out_of_range, value}
    logic               ovf_hit;

    // Scale by 2^-SH, round the discarded LSBs, then range check with the carry included.
    function automatic logic [DW:0] round_sat(input logic signed [RW-1:0] v);
        logic [SH-1:0]      frac;
        logic               up;
        logic signed [QW:0] r;
        logic               oor;
        logic [DW-1:0]      z;
        frac = v[SH-1:0];
        case (ROUND_MODE)
            0:       up = 1'b0;
            1:       up = (frac > HALF) || ((frac == HALF) && v[SH]);
            default: up = (frac >= HALF);
        endcase
        r   = $signed({v[RW-1], v[RW-1:SH]}) + $signed({{QW{1'b0}}, up});
        oor = (r[QW:DW-1] != {(QW-DW+2){r[QW]}});
        if (oor && (SATURATE != 0))
            z = r[QW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            z = r[DW-1:0];
        return {oor, z};
    endfunction

    // Sign-extend w_im by one bit so that negating the most negative value is exact.
    always_comb begin
        wim_ext = $signed({w_im_i[TW-1], w_im_i});
        wim_sel = conj_i ? -wim_ext : wim_ext;
    end

    // S1: capture the inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_xre <= '0; s1_xim <= '0; s1_wre <= '0; s1_wim <= '0;
        end else if (en_i) begin
            s1_xre <= $signed(x_re_i);
            s1_xim <= $signed(x_im_i);
            s1_wre <= $signed(w_re_i);
            s1_wim <= wim_sel;
        end
    end

    // S2: Karatsuba pre-adds e = xr - xi, c - d, c + d.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_xre <= '0; s2_xim <= '0; s2_wre <= '0;
            s2_e   <= '0; s2_cmd <= '0; s2_cpd <= '0;
        end else if (en_i) begin
            s2_xre <= s1_xre;
            s2_xim <= s1_xim;
            s2_wre <= s1_wre;
            s2_e   <= (DW+1)'(s1_xre) - (DW+1)'(s1_xim);
            s2_cmd <= (TW+2)'(s1_wre) - (TW+2)'(s1_wim);
            s2_cpd <= (TW+2)'(s1_wre) + (TW+2)'(s1_wim);
        end
    end

    // S3: the three real multiplies.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s3_f <= '0; s3_pr <= '0; s3_pi <= '0;
        end else if (en_i) begin
            s3_f  <= RW'(s2_wre) * RW'(s2_e);
            s3_pr <= RW'(s2_xim) * RW'(s2_cmd);
            s3_pi <= RW'(s2_xre) * RW'(s2_cpd);
        end
    end

    // S4: post-adds give the exact real and imaginary products.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s4_r <= '0; s4_i <= '0;
        end else if (en_i) begin
            s4_r <= s3_pr + s3_f;
            s4_i <= s3_pi - s3_f;
        end
    end

    // Valid and counter shift registers in lockstep with the data stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            ctr_pipe <= '0;
        end else if (en_i) begin
            vld_pipe <= {vld_pipe[3:1], valid_i};
            ctr_pipe <= {ctr_pipe[3:1], ctr_i};
        end
    end

    // Rounding and range check feeding S5; bubbles never flag overflow.
    always_comb begin
        rs_re   = round_sat(s4_r);
        rs_im   = round_sat(s4_i);
        ovf_hit = vld_pipe[4] & (rs_re[DW] | rs_im[DW]);
    end

    // S5: output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            ctr_o   <= '0;
            z_re_o  <= '0;
            z_im_o  <= '0;
        end else if (en_i) begin
            valid_o <= vld_pipe[4];
            ctr_o   <= ctr_pipe[4];
            z_re_o  <= rs_re[DW-1:0];
            z_im_o  <= rs_im[DW-1:0];
        end
    end

    // Sticky overflow: a new overflow beats a simultaneous clear; clear works while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ovf_o <= 1'b0;
        else if (en_i && ovf_hit)
            ovf_o <= 1'b1;
        else if (clr_ovf_i)
            ovf_o <= 1'b0;
    end

endmodule

// File: doc/fft_cmul_pipe.md
Name: fft_cmul_pipe

Overview:
Parametrised, fully pipelined complex multiplier for the R22SDF FFT twiddle stage. It computes z = x * w (or x * conj(w) for the inverse transform) on a single clock using three real multiplies (Karatsuba). It supports selectable rounding, optional saturation with a sticky overflow flag, a valid/stall pipeline and counter passthrough. It sits between a butterfly stage and the next stage in place of the earlier 3x-clock multiplier.

Parameters:
DATA_WIDTH, 25, width of x and z components (signed)
TWIDDLE_WIDTH, 10, width of w components (signed, Q1.(TWIDDLE_WIDTH-1); +1.0 is not representable)
NLOG2, 10, counter width
ROUND_MODE, 1, 0=truncate (floor), 1=convergent (half-to-even), 2=round half up (floor(v+0.5))
SATURATE, 1, 1=clamp to DATA_WIDTH range, 0=two's-complement wrap

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
en_i  in  1  pipeline advance; 0 holds every stage
clr_ovf_i  in  1  synchronous clear of ovf_o
conj_i  in  1  1: multiply by conj(w); sampled with the data
valid_i  in  1  input sample valid
ctr_i  in  NLOG2  sample counter, passed through
x_re_i, x_im_i  in  DATA_WIDTH each  signed data
w_re_i, w_im_i  in  TWIDDLE_WIDTH each  signed twiddle
valid_o  out  1  output valid
ctr_o  out  NLOG2  delayed ctr_i
z_re_o, z_im_o  out  DATA_WIDTH each  signed product
ovf_o  out  1  sticky overflow flag

Behaviour:
- Reset (async assert, sync release on the clk_i edge) clears all pipeline valid bits, valid_o, ctr_o, z_re_o, z_im_o and ovf_o to 0. Reset mid-stream discards all in-flight samples; no partial output appears.
- Latency: 5 enabled cycles (en_i=1), input to output. Stages:
  - S1: register the inputs. If conj_i=1, w_im is replaced by its negation, computed at TWIDDLE_WIDTH+1 bits so -(-2^(TW-1)) is exact.
  - S2: pre-adds, at full width, no truncation: e = x_re - x_im, c-d, c+d.
  - S3: three signed multiplies: f = w_re*e, p_r = x_im*(c-d), p_i = x_re*(c+d).
  - S4: R = p_r + f, I = p_i - f, width DATA_WIDTH+TWIDDLE_WIDTH+2.
  - S5: scale by 2^-(TWIDDLE_WIDTH-1), round, saturate/wrap, register to outputs.
- The result is exact before rounding: R = x_re*w_re - x_im*w_im', I = x_re*w_im' + x_im*w_re, where w_im' is the (possibly negated) w_im.
- Rounding operates on the discarded TWIDDLE_WIDTH-1 LSBs, per ROUND_MODE. A rounding carry is applied before range checking.
- Range check against [-2^(DW-1), 2^(DW-1)-1]:
  - SATURATE=1: clamp to the nearest bound.
  - SATURATE=0: keep the low DATA_WIDTH bits.
  - In both modes an out-of-range result on a valid sample sets ovf_o on the following edge.
- ovf_o is sticky until clr_ovf_i=1 or reset. If a new overflow and clr_ovf_i occur in the same cycle, the set wins.
- en_i=0: all stage registers, valid bits, ctr pipeline and outputs hold their values; ovf_o can still be cleared. valid_o stays at its held value, so downstream must qualify with its own enable.
- Bubbles (valid_i=0) propagate; the data path computes on whatever is present, but valid_o=0 for those slots and they never set ovf_o.
- ctr_o and valid_o are delayed exactly in lockstep with the data.
- Throughput: one sample per enabled cycle, no back-pressure beyond en_i.

Test Plan:
1. DW=25, TW=10, mode 1, x=(1000,-1000), w=(511,0) -> 5 cycles later z=(998,-998), valid_o=1, ctr_o equals the ctr_i sent.
2. Rounding ties, w=(256,0):
   - x=(1,0): mode0 z_re=0, mode1 0, mode2 1.
   - x=(3,0): mode1 z_re=2.
   - x=(-1,0): mode0 -1, mode1 0, mode2 0.
3. conj_i, x=(100,0), w=(0,256): conj_i=0 -> z=(0,50); conj_i=1 -> z=(0,-50).
4. Overflow, x=(2^24-1, 2^24-1), w=(-512,-512):
   - SATURATE=1 -> z=(0,-2^24), ovf_o=1 and stays 1 until a clr_ovf_i pulse, after which it reads 0.
   - SATURATE=0 -> z_im=2, ovf_o=1.
5. Stream of 8 valid samples with en_i=0 for 3 cycles mid-stream -> outputs hold during the stall; all 8 results are correct, in order, with no duplicates; valid_o count is 8.
6. rst_i asserted asynchronously mid-edge with 3 samples in flight -> valid_o, z and ovf_o go to 0 immediately; after release, a new sample emerges exactly 5 cycles later and no stale sample appears.
